// File: rtl/atm_session_ctrl.sv
// Session sequencer for the ATM datapath: menu flow, request/reply handshakes,
// PIN-retry lockout, reply timeout and inactivity abort.
module atm_session_ctrl #(
  parameter int MAX_PIN_TRIES = 3,
  parameter int RESP_TIMEOUT  = 16,
  parameter int INACT_TIMEOUT = 1000000,
  parameter int MSG_CYCLES    = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enter,
  input  logic        back,
  input  logic [1:0]  menuOption,
  input  logic [3:0]  status_code,
  output logic [15:0] current_state,
  output logic        ready,
  output logic [3:0]  status_code_fwd,
  output logic        authenticated,
  output logic [1:0]  pin_attempts,
  output logic        locked
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_ACC_NUM    = 4'd1,
    S_PIN_INPUT  = 4'd2,
    S_MENU       = 4'd3,
    S_SHOW_BAL   = 4'd4,
    S_CONVERT    = 4'd5,
    S_SEL_CONV_1 = 4'd6,
    S_SEL_CONV_2 = 4'd7,
    S_WITHDRAW   = 4'd8,
    S_SEL_AMT_WD = 4'd9,
    S_TRANSFER   = 4'd10,
    S_SEL_CUR_TR = 4'd11,
    S_SEL_AMT_TR = 4'd12,
    S_ERROR      = 4'd13,
    S_SUCCESS    = 4'd14
  } state_t;

  // Handshake: a request state raises ready for one cycle and sets await_reply;
  // status_code is then sampled every cycle once ready has dropped, and the
  // first code expected for that state ends the request.
  state_t      state, state_nxt;
  logic        await_reply, await_nxt;
  logic        ready_nxt;
  logic [3:0]  fwd_nxt;
  logic        auth_nxt, locked_nxt;
  logic [1:0]  pin_nxt, pin_inc;
  logic        resolved, timer_reload, in_flow;
  // One timer serves reply timeout, message hold and inactivity; the modes never overlap.
  logic [31:0] timer;

  assign in_flow = (state >= S_ACC_NUM) && (state <= S_SEL_AMT_TR);
  assign pin_inc = pin_attempts + 2'd1;

  always_comb begin
    state_nxt    = state;
    await_nxt    = await_reply;
    ready_nxt    = 1'b0;
    fwd_nxt      = 4'd0;
    auth_nxt     = authenticated;
    pin_nxt      = pin_attempts;
    locked_nxt   = locked;
    resolved     = 1'b0;
    timer_reload = 1'b0;

    if (await_reply) begin
      if (!ready) begin
        case (state)
          S_ACC_NUM, S_TRANSFER: begin
            if (status_code == 4'd1) begin
              resolved  = 1'b1;
              state_nxt = (state == S_ACC_NUM) ? S_PIN_INPUT : S_SEL_CUR_TR;
            end else if (status_code == 4'd2) begin
              resolved  = 1'b1;
              state_nxt = S_ERROR;
            end
          end
          S_PIN_INPUT: begin
            if (status_code == 4'd3) begin
              resolved  = 1'b1;
              state_nxt = S_MENU;
              auth_nxt  = 1'b1;
              pin_nxt   = 2'd0;
            end else if (status_code == 4'd4) begin
              resolved = 1'b1;
              pin_nxt  = pin_inc;
              if (pin_inc == 2'(MAX_PIN_TRIES)) begin
                locked_nxt = 1'b1;
                state_nxt  = S_ERROR;
              end
            end
          end
          S_SEL_CONV_1, S_SEL_AMT_WD, S_SEL_AMT_TR: begin
            if (status_code == 4'd5) begin
              resolved  = 1'b1;
              state_nxt = (state == S_SEL_CONV_1) ? S_SEL_CONV_2 : S_SUCCESS;
            end else if (status_code == 4'd6) begin
              resolved  = 1'b1;
              state_nxt = S_ERROR;
            end
          end
          default: ;
        endcase
      end
      if (resolved) begin
        await_nxt    = 1'b0;
        timer_reload = 1'b1;
      end else if (timer == 32'(RESP_TIMEOUT - 1)) begin
        await_nxt = 1'b0;
        state_nxt = S_ERROR;
      end
    end else if (state == S_ERROR || state == S_SUCCESS) begin
      if (timer == 32'(MSG_CYCLES - 1))
        state_nxt = (locked || !authenticated) ? S_IDLE : S_MENU;
    end else if (back) begin
      if (in_flow) begin
        timer_reload = 1'b1;
        state_nxt    = (state <= S_MENU) ? S_IDLE : S_MENU;
      end
    end else if (enter) begin
      timer_reload = 1'b1;
      case (state)
        S_IDLE:       if (!locked) state_nxt = S_ACC_NUM;
        S_ACC_NUM, S_PIN_INPUT, S_SEL_CONV_1, S_SEL_AMT_WD, S_TRANSFER, S_SEL_AMT_TR: begin
          ready_nxt = 1'b1;
          await_nxt = 1'b1;
        end
        S_MENU: begin
          case (menuOption)
            2'd0:    state_nxt = S_SHOW_BAL;
            2'd1:    state_nxt = S_CONVERT;
            2'd2:    state_nxt = S_WITHDRAW;
            default: state_nxt = S_TRANSFER;
          endcase
        end
        S_SHOW_BAL:   state_nxt = S_MENU;
        S_CONVERT:    state_nxt = S_SEL_CONV_1;
        S_WITHDRAW:   state_nxt = S_SEL_AMT_WD;
        S_SEL_CUR_TR: state_nxt = S_SEL_AMT_TR;
        S_SEL_CONV_2: begin
          ready_nxt = 1'b1;
          state_nxt = S_SUCCESS;
        end
        default: ;
      endcase
    end else if (in_flow && timer == 32'(INACT_TIMEOUT - 1)) begin
      state_nxt = S_IDLE;
      fwd_nxt   = 4'd7;
    end

    if (state_nxt == S_IDLE) begin
      auth_nxt = 1'b0;
      pin_nxt  = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      current_state   <= 16'h0001;
      await_reply     <= 1'b0;
      ready           <= 1'b0;
      status_code_fwd <= 4'd0;
      authenticated   <= 1'b0;
      pin_attempts    <= 2'd0;
      locked          <= 1'b0;
      timer           <= 32'd0;
    end else begin
      state           <= state_nxt;
      current_state   <= 16'd1 << state_nxt;
      await_reply     <= await_nxt;
      ready           <= ready_nxt;
      status_code_fwd <= fwd_nxt;
      authenticated   <= auth_nxt;
      pin_attempts    <= pin_nxt;
      locked          <= locked_nxt;
      if (state_nxt != state || timer_reload || state == S_IDLE)
        timer <= 32'd0;
      else
        timer <= timer + 32'd1;
    end
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl: session flows, lockout, timeouts and
// asynchronous reset, with hand-computed expectations.
module tb_atm_session_ctrl;

  localparam int MSG   = 20;
  localparam int RESP  = 16;
  localparam int INACT = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enter = 1'b0;
  logic        back = 1'b0;
  logic [1:0]  menuOption = 2'd0;
  logic [3:0]  status_code = 4'd0;
  logic [15:0] current_state;
  logic        ready;
  logic [3:0]  status_code_fwd;
  logic        authenticated;
  logic [1:0]  pin_attempts;
  logic        locked;

  int total = 0;
  int bad = 0;
  int ready_cnt = 0;
  logic [15:0] exp_q[$];

  atm_session_ctrl #(
    .MAX_PIN_TRIES(3),
    .RESP_TIMEOUT (RESP),
    .INACT_TIMEOUT(INACT),
    .MSG_CYCLES   (MSG)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enter          (enter),
    .back           (back),
    .menuOption     (menuOption),
    .status_code    (status_code),
    .current_state  (current_state),
    .ready          (ready),
    .status_code_fwd(status_code_fwd),
    .authenticated  (authenticated),
    .pin_attempts   (pin_attempts),
    .locked         (locked)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (ready) ready_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks (all driving and sampling on the falling edge)
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic pulse_enter();
    @(negedge clk) enter = 1'b1;
    @(negedge clk) enter = 1'b0;
  endtask

  task automatic pulse_back();
    @(negedge clk) back = 1'b1;
    @(negedge clk) back = 1'b0;
  endtask

  // Issue a request with enter, confirm the ready strobe, then reply once.
  task automatic request(input string tag, input logic [3:0] code);
    pulse_enter();
    check({tag, "_ready"}, ready, 1'b1);
    @(negedge clk) status_code = code;
    @(negedge clk) status_code = 4'd0;
  endtask

  task automatic login();
    pulse_enter();
    request("login_acc", 4'd1);
    request("login_pin", 4'd3);
    check("login_menu", current_state, 16'h0008);
  endtask

  initial begin
    // reset values while rst is held
    tick(2);
    check("rst_state", current_state, 16'h0001);
    check("rst_ready", ready, 1'b0);
    check("rst_fwd", status_code_fwd, 4'd0);
    check("rst_auth", authenticated, 1'b0);
    check("rst_pin", pin_attempts, 2'd0);
    check("rst_locked", locked, 1'b0);
    @(negedge clk) rst = 1'b0;
    ready_cnt = 0;

    // normal withdraw
    exp_q = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0100, 16'h0200, 16'h4000};
    tick(1);
    check("wd_idle", current_state, exp_q.pop_front());
    pulse_enter();
    check("wd_acc", current_state, exp_q.pop_front());
    request("wd_acc", 4'd1);
    check("wd_pin", current_state, exp_q.pop_front());
    request("wd_pin", 4'd3);
    check("wd_menu", current_state, exp_q.pop_front());
    check("wd_auth", authenticated, 1'b1);
    menuOption = 2'd2;
    pulse_enter();
    check("wd_withdraw", current_state, exp_q.pop_front());
    pulse_enter();
    check("wd_sel_amt", current_state, exp_q.pop_front());
    request("wd_amt", 4'd5);
    check("wd_success", current_state, exp_q.pop_front());
    check("wd_ready_count", ready_cnt, 3);
    tick(MSG - 1);
    check("wd_msg_hold", current_state, 16'h4000);
    tick(1);
    check("wd_back_menu", current_state, 16'h0008);
    check("wd_auth_kept", authenticated, 1'b1);

    // PIN lockout
    pulse_back();
    check("lk_idle", current_state, 16'h0001);
    check("lk_auth_clr", authenticated, 1'b0);
    pulse_enter();
    request("lk_acc", 4'd1);
    request("lk_pin1", 4'd4);
    check("lk_pin1_cnt", pin_attempts, 2'd1);
    check("lk_pin1_state", current_state, 16'h0004);
    request("lk_pin2", 4'd4);
    check("lk_pin2_cnt", pin_attempts, 2'd2);
    request("lk_pin3", 4'd4);
    check("lk_locked", locked, 1'b1);
    check("lk_error", current_state, 16'h2000);
    tick(MSG);
    check("lk_to_idle", current_state, 16'h0001);
    check("lk_pin_clr", pin_attempts, 2'd0);
    pulse_enter();
    check("lk_enter_ignored", current_state, 16'h0001);
    check("lk_sticky", locked, 1'b1);

    // response timeout
    do_reset();
    check("to_unlocked", locked, 1'b0);
    pulse_enter();
    pulse_enter();
    check("to_ready", ready, 1'b1);
    tick(RESP - 1);
    check("to_still_waiting", current_state, 16'h0002);
    tick(1);
    check("to_error", current_state, 16'h2000);
    check("to_auth", authenticated, 1'b0);
    tick(MSG);
    check("to_idle", current_state, 16'h0001);

    // transfer with unknown destination account
    login();
    menuOption = 2'd3;
    pulse_enter();
    check("tr_transfer", current_state, 16'h0400);
    request("tr_acc", 4'd2);
    check("tr_error", current_state, 16'h2000);
    tick(MSG);
    check("tr_menu", current_state, 16'h0008);

    // inactivity abort in WITHDRAW
    menuOption = 2'd2;
    pulse_enter();
    check("in_withdraw", current_state, 16'h0100);
    tick(INACT - 1);
    check("in_not_yet", current_state, 16'h0100);
    check("in_fwd_quiet", status_code_fwd, 4'd0);
    tick(1);
    check("in_idle", current_state, 16'h0001);
    check("in_fwd_exit", status_code_fwd, 4'd7);
    tick(1);
    check("in_fwd_one_cycle", status_code_fwd, 4'd0);

    // enter and back together: back wins
    login();
    menuOption = 2'd0;
    pulse_enter();
    check("eb_show", current_state, 16'h0010);
    @(negedge clk) begin enter = 1'b1; back = 1'b1; end
    @(negedge clk) begin enter = 1'b0; back = 1'b0; end
    check("eb_menu", current_state, 16'h0008);

    // convert: second currency step strobes ready and completes without a reply
    menuOption = 2'd1;
    pulse_enter();
    pulse_enter();
    check("cv_sel1", current_state, 16'h0040);
    request("cv_sel1", 4'd6 - 4'd1);
    check("cv_sel2", current_state, 16'h0080);
    pulse_enter();
    check("cv_ready", ready, 1'b1);
    check("cv_success", current_state, 16'h4000);
    tick(MSG);
    check("cv_menu", current_state, 16'h0008);

    // asynchronous reset while a transfer amount request is pending
    menuOption = 2'd3;
    pulse_enter();
    request("ar_acc", 4'd1);
    check("ar_sel_cur", current_state, 16'h0800);
    pulse_enter();
    check("ar_sel_amt", current_state, 16'h1000);
    pulse_enter();
    check("ar_ready", ready, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("ar_state", current_state, 16'h0001);
    check("ar_ready_clr", ready, 1'b0);
    check("ar_auth_clr", authenticated, 1'b0);
    check("ar_pin_clr", pin_attempts, 2'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) status_code = 4'd5;
    @(negedge clk) status_code = 4'd0;
    tick(1);
    check("ar_late_reply", current_state, 16'h0001);
    check("ar_no_ready", ready, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
